// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: size and FSM state encodings shared by mem_responder and mem_lane_align
package mem_resp_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, lane-shifted store data and extended load data from addr[1:0]/size
module mem_lane_align import mem_resp_pkg::*; (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  always_comb begin
    sh = rword >> {addr_lo, 3'b000};
    be = size == SZ_BYTE ? 4'b0001 << addr_lo
       : size == SZ_HALF ? 4'b0011 << {addr_lo[1], 1'b0}
       : 4'b1111;
    wdata_lane = size == SZ_BYTE ? wdata << {addr_lo, 3'b000}
               : size == SZ_HALF ? wdata << {addr_lo[1], 4'b0000}
               : wdata;
    rdata = size == SZ_BYTE ? {{24{sh[7] & ~uns}}, sh[7:0]}
          : size == SZ_HALF ? {{16{sh[15] & ~uns}}, sh[15:0]}
          : rword;
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder with LATENCY wait states; MEM_RESP_FAULT_EN enables fault detection
module mem_responder import mem_resp_pkg::*; #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  logic [31:0] mem [DEPTH];
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic c_write, c_uns, a_write, a_uns;
  logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
  logic [1:0] c_size, a_size, lo;
  logic accept, fault, last, commit;
  logic [AW-1:0] idx;
  logic [3:0] be;
  logic [31:0] wlane, rext;
  // In IDLE the access being committed (LATENCY=0 or fault) is the one on the request port
  always_comb begin
    a_write = state == ST_IDLE ? req_write : c_write;
    a_addr  = state == ST_IDLE ? req_addr : c_addr;
    a_wdata = state == ST_IDLE ? req_wdata : c_wdata;
    a_size  = state == ST_IDLE ? req_size : c_size;
    a_uns   = state == ST_IDLE ? req_unsigned : c_uns;
  end
`ifdef MEM_RESP_FAULT_EN
  assign fault = (a_size == SZ_HALF && a_addr[0]) || (a_size[1] && |a_addr[1:0]) ||
                 ({2'b00, a_addr[31:2]} >= 32'(DEPTH));
  assign lo = a_addr[1:0];
`else
  logic [31:0] unused_addr;
  assign unused_addr = a_addr;
  assign fault = 1'b0;
  assign lo = {a_addr[1] & ~a_size[1], a_addr[0] & (a_size == SZ_BYTE)};
`endif
  assign idx = a_addr[AW+1:2];
  mem_lane_align u_align (
    .addr_lo   (lo),
    .size      (a_size),
    .uns       (a_uns),
    .wdata     (a_wdata),
    .rword     (mem[idx]),
    .be        (be),
    .wdata_lane(wlane),
    .rdata     (rext)
  );
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= state_n;
  always_comb begin
    accept = req_valid && state == ST_IDLE;
    last = cnt == CW'(LATENCY - 1);
    state_n = state == ST_IDLE ? (accept ? ((fault || LATENCY == 0) ? ST_RESP : ST_WAIT) : ST_IDLE)
            : state == ST_WAIT ? (last ? ST_RESP : ST_WAIT)
            : (resp_ready ? ST_IDLE : ST_RESP);
    commit = state_n == ST_RESP && state != ST_RESP;
  end
  always_comb begin
    req_ready = state == ST_IDLE;
    resp_valid = state == ST_RESP;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      cnt <= state == ST_WAIT && !last ? cnt + 1'b1 : '0;
      if (accept) {c_write, c_addr, c_wdata, c_size, c_uns} <= {req_write, req_addr, req_wdata, req_size, req_unsigned};
      if (commit) begin
        resp_rdata <= fault || a_write ? '0 : rext;
        resp_fault <= fault;
      end
    end
  always_ff @(posedge clk)
    if (!reset && commit && a_write && !fault)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder (DEPTH=1024, LATENCY=2)
module tb_mem_responder;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_write = 0, req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic resp_valid, resp_ready = 0, resp_fault;
  logic [31:0] resp_rdata;
  logic [32:0] exp_q[$];
  int vecs = 0, errs = 0;
  mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic garbage(input logic v);
    req_valid = v;
    req_write = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
  endtask
  task automatic send(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic u, input logic [31:0] er, input logic ef,
                      input int lat, input int hold);
    int n;
    logic [32:0] e;
    logic [31:0] first;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
    n = 0;
    while (!req_ready && n < 50) begin tick; n++; end
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    tick;
    exp_q.push_back({ef, er});
    garbage(1'b0);
    n = 1;
    while (!resp_valid && n < 50) begin tick; n++; end
    chk({tag, "_latency"}, n, lat);
    first = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      garbage(1'b1);
      tick;
      chk({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, first);
      chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1;
    vecs++;
    assert (exp_q.size() != 0) else begin
      errs++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, resp_rdata, e[31:0]);
      chk({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, e[32]});
    end
    tick;
    resp_ready = 0;
    chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_valid_after"}, {31'd0, resp_valid}, 32'd0);
    req_valid = 0;
  endtask
  initial begin
    tick; tick;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fault", {31'd0, resp_fault}, 32'd0);
    reset = 0;
    tick;
    dut.mem[0] = 32'h0;
    dut.mem[1] = 32'h80FF7F01;
    dut.mem[2] = 32'h11223344;
    dut.mem[3] = 32'hDEADBEEF;
    dut.mem[4] = 32'h12345678;
    send("sw0", 1, 32'h0, 32'h8, 2'b10, 0, 32'h0, 0, 3, 0);
    chk("mem0", dut.mem[0], 32'h8);
    send("lb6", 0, 32'h6, 32'h0, 2'b00, 0, 32'hFFFFFFFF, 0, 3, 0);
    send("lbu6", 0, 32'h6, 32'h0, 2'b00, 1, 32'h000000FF, 0, 3, 0);
    send("lb7", 0, 32'h7, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0, 3, 0);
    send("lbu7", 0, 32'h7, 32'h0, 2'b00, 1, 32'h00000080, 0, 3, 0);
    send("lb5", 0, 32'h5, 32'h0, 2'b00, 0, 32'h0000007F, 0, 3, 0);
    send("lh4", 0, 32'h4, 32'h0, 2'b01, 0, 32'h00007F01, 0, 3, 0);
    send("lh6", 0, 32'h6, 32'h0, 2'b01, 0, 32'hFFFF80FF, 0, 3, 0);
    send("lhu6", 0, 32'h6, 32'h0, 2'b01, 1, 32'h000080FF, 0, 3, 0);
    send("lwu4", 0, 32'h4, 32'h0, 2'b10, 1, 32'h80FF7F01, 0, 3, 0);
    send("shA", 1, 32'hA, 32'h1234ABCD, 2'b01, 0, 32'h0, 0, 3, 0);
    chk("mem2_sh", dut.mem[2], 32'hABCD3344);
    send("sb9", 1, 32'h9, 32'hFFFFFFEE, 2'b00, 0, 32'h0, 0, 3, 0);
    chk("mem2_sb", dut.mem[2], 32'hABCDEE44);
    send("lw_bp", 0, 32'hC, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 3, 4);
    send("lw_sz3", 0, 32'hC, 32'h0, 2'b11, 0, 32'hDEADBEEF, 0, 3, 0);
`ifdef MEM_RESP_FAULT_EN
    send("lw_mis", 0, 32'h2, 32'h0, 2'b10, 0, 32'h0, 1, 1, 0);
    send("lh_mis", 0, 32'h5, 32'h0, 2'b01, 0, 32'h0, 1, 1, 0);
    send("sw_oob", 1, 32'h1000, 32'h99, 2'b10, 0, 32'h0, 1, 1, 0);
    chk("mem0_oob", dut.mem[0], 32'h8);
    send("sh_mis", 1, 32'hD, 32'hBBBB, 2'b01, 0, 32'h0, 1, 1, 2);
    chk("mem3_mis", dut.mem[3], 32'hDEADBEEF);
`else
    send("lw_mis", 0, 32'h2, 32'h0, 2'b10, 0, 32'h8, 0, 3, 0);
    send("lh_mis", 0, 32'h5, 32'h0, 2'b01, 0, 32'h00007F01, 0, 3, 0);
    send("sw_wrap", 1, 32'h1000, 32'h99, 2'b10, 0, 32'h0, 0, 3, 0);
    chk("mem0_wrap", dut.mem[0], 32'h99);
    send("sh_mis", 1, 32'hD, 32'hBBBB, 2'b01, 0, 32'h0, 0, 3, 0);
    chk("mem3_mis", dut.mem[3], 32'hDEADBBBB);
`endif
    req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'h55; req_size = 2'b10; req_unsigned = 0;
    tick;
    garbage(1'b0);
    reset = 1;
    tick;
    reset = 0;
    chk("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) tick;
    chk("rstw_mem4", dut.mem[4], 32'h12345678);
    chk("rstw_idle_valid", {31'd0, resp_valid}, 32'd0);
    send("lw_after_rst", 0, 32'h10, 32'h0, 2'b10, 0, 32'h12345678, 0, 3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
